// File: rtl/swd_host_phy_if.sv
// swd_host_phy_if: request/response bundle for the SWD host engine.
// master = command source, slave = swd_host_phy.
interface swd_host_phy_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_lrst;
   logic        req_apndp;
   logic        req_rnw;
   logic [1:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [2:0]  rsp_ack;
   logic [31:0] rsp_rdata;
   logic        rsp_perr;
   logic [3:0]  rsp_retries;

   modport master (
      output req_valid, req_lrst, req_apndp,
      output req_rnw, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_ack,
      input  rsp_rdata, rsp_perr, rsp_retries
   );

   modport slave (
      input  req_valid, req_lrst, req_apndp,
      input  req_rnw, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_ack,
      output rsp_rdata, rsp_perr, rsp_retries
   );
endinterface

// File: rtl/swd_host_phy.sv
// swd_host_phy: SWD initiator; one DP/AP transaction or line reset per
// request, one response beat back.
// Ports: hclk, RESETn (sync, active-low), bus (swd_host_phy_if.slave),
// SWDCLK/SWDOUT/SWDOE to the pin IOBUF, SWDIN from the synchroniser.
// Option: SWD_HOST_WAIT_RETRY_EN re-issues the request on WAIT.
// IDLE_CYCLES is expected to be >= 1.
module swd_host_phy #(
   parameter int CLK_DIV     = 2,
   parameter int IDLE_CYCLES = 2,
   parameter int RETRY_MAX   = 15
) (
   input  logic          hclk,
   input  logic          RESETn,
   swd_host_phy_if.slave bus,
   output logic          SWDCLK,
   output logic          SWDOUT,
   output logic          SWDOE,
   input  logic          SWDIN
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [3:0] IDLE  = 4'd0;
   localparam logic [3:0] LRST  = 4'd1;
   localparam logic [3:0] REQ   = 4'd2;
   localparam logic [3:0] TRN1  = 4'd3;
   localparam logic [3:0] ACK   = 4'd4;
   localparam logic [3:0] RDATA = 4'd5;
   localparam logic [3:0] TRN2  = 4'd6;
   localparam logic [3:0] WDATA = 4'd7;
   localparam logic [3:0] TAIL  = 4'd8;
   localparam logic [3:0] DONE  = 4'd9;

   localparam logic [2:0] A_OK   = 3'b001;
   localparam logic [2:0] A_WAIT = 3'b010;

   logic [3:0]    st, nxt, ns;
   logic [5:0]    bit_q, last, nb;
   logic [DW-1:0] div_q;
   logic          ph, live, tick;
   logic          d_out, d_oe, retry;
   logic          apndp_q, rnw_q;
   logic [1:0]    addr_q;
   logic [31:0]   wdata_q, rdata_q;
   logic [2:0]    ack_q;
   logic          perr_q;
   logic [7:0]    req_byte;
`ifdef SWD_HOST_WAIT_RETRY_EN
   logic [3:0]    retries_q;
`endif

   assign tick = div_q == DW'(CLK_DIV - 1);

   // start, APnDP, RnW, A2, A3, parity, stop, park
   assign req_byte = {1'b1, 1'b0,
                      apndp_q ^ rnw_q ^ addr_q[0] ^ addr_q[1],
                      addr_q[1], addr_q[0], rnw_q, apndp_q, 1'b1};

   // index of the final bit of the current state
   always_comb begin
      last = 6'd0;
      case (st)
         LRST:         last = 6'd63;
         REQ:          last = 6'd7;
         ACK:          last = 6'd2;
         RDATA, WDATA: last = 6'd32;
         TAIL:         last = 6'(IDLE_CYCLES - 1);
         default:      last = 6'd0;
      endcase
   end

`ifdef SWD_HOST_WAIT_RETRY_EN
   assign retry = (ack_q == A_WAIT) &&
                  (retries_q < 4'(RETRY_MAX));
`else
   assign retry = 1'b0;
`endif

   always_comb begin
      nxt = st;
      case (st)
         LRST:  nxt = DONE;
         REQ:   nxt = TRN1;
         TRN1:  nxt = ACK;
         ACK:   nxt = (ack_q == A_OK && rnw_q) ? RDATA : TRN2;
         RDATA: nxt = TRN2;
         TRN2:  nxt = (ack_q == A_OK && !rnw_q) ? WDATA : TAIL;
         WDATA: nxt = TAIL;
         TAIL:  nxt = retry ? REQ : DONE;
         default: nxt = st;
      endcase
   end

   // state/bit that the next SWDCLK fall starts
   always_comb begin
      ns = (bit_q == last) ? nxt : st;
      nb = (bit_q == last) ? 6'd0 : bit_q + 6'd1;
   end

   always_comb begin
      d_out = 1'b0;
      d_oe  = 1'b1;
      case (ns)
         LRST:  d_out = nb < 6'd56;
         REQ:   d_out = req_byte[nb[2:0]];
         TRN1, ACK, RDATA, TRN2: d_oe = 1'b0;
         WDATA: d_out = nb[5] ? ^wdata_q : wdata_q[nb[4:0]];
         default: ;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (!RESETn) begin
         st      <= IDLE;
         live    <= 1'b0;
         div_q   <= '0;
         ph      <= 1'b0;
         bit_q   <= '0;
         SWDCLK  <= 1'b0;
         SWDOUT  <= 1'b0;
         SWDOE   <= 1'b0;
         apndp_q <= 1'b0;
         rnw_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ack_q   <= '0;
         rdata_q <= '0;
         perr_q  <= 1'b0;
`ifdef SWD_HOST_WAIT_RETRY_EN
         retries_q <= '0;
`endif
      end else begin
         live <= 1'b1;
         if (st == IDLE) begin
            SWDCLK <= 1'b0;
            SWDOUT <= 1'b0;
            SWDOE  <= 1'b1;
            div_q  <= '0;
            ph     <= 1'b0;
            bit_q  <= '0;
            if (bus.req_valid && bus.req_ready) begin
               st      <= bus.req_lrst ? LRST : REQ;
               apndp_q <= bus.req_apndp;
               rnw_q   <= bus.req_rnw;
               addr_q  <= bus.req_addr;
               wdata_q <= bus.req_wdata;
               ack_q   <= '0;
               rdata_q <= '0;
               perr_q  <= 1'b0;
`ifdef SWD_HOST_WAIT_RETRY_EN
               retries_q <= '0;
`endif
               // first bit is 1 for both line reset and start bit
               SWDOUT  <= 1'b1;
            end
         end else if (st == DONE) begin
            st <= IDLE;
         end else begin
            div_q <= tick ? '0 : div_q + DW'(1);
            if (tick) begin
               ph     <= ~ph;
               SWDCLK <= ~ph;
               if (!ph) begin
                  if (st == ACK)
                     ack_q[bit_q[1:0]] <= SWDIN;
                  if (st == RDATA) begin
                     if (bit_q[5])
                        perr_q <= (^rdata_q) ^ SWDIN;
                     else
                        rdata_q[bit_q[4:0]] <= SWDIN;
                  end
               end else begin
                  st     <= ns;
                  bit_q  <= nb;
                  SWDOUT <= d_out;
                  SWDOE  <= d_oe;
`ifdef SWD_HOST_WAIT_RETRY_EN
                  if (st == TAIL && bit_q == last && retry)
                     retries_q <= retries_q + 4'd1;
`endif
               end
            end
         end
      end
   end

   assign bus.req_ready = live & (st == IDLE);
   assign bus.rsp_valid = st == DONE;
   assign bus.rsp_ack   = ack_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_perr  = perr_q;
`ifdef SWD_HOST_WAIT_RETRY_EN
   assign bus.rsp_retries = retries_q;
`else
   assign bus.rsp_retries = 4'd0;
`endif
endmodule

// File: tb/tb_swd_host_phy.sv
// tb_swd_host_phy: bench for swd_host_phy with a bit-list target model.
// Expected pin waveform is derived per hclk from bit index arithmetic.
module tb_swd_host_phy;
   localparam int CD = 2;
   localparam int IC = 2;
   localparam int RM = 15;
   localparam int P  = 2 * CD;

   logic hclk   = 1'b0;
   logic RESETn = 1'b0;
   logic SWDIN  = 1'b0;
   logic SWDCLK, SWDOUT, SWDOE;

   swd_host_phy_if bus ();

   swd_host_phy #(
      .CLK_DIV(CD), .IDLE_CYCLES(IC), .RETRY_MAX(RM)
   ) dut (
      .hclk(hclk), .RESETn(RESETn), .bus(bus),
      .SWDCLK(SWDCLK), .SWDOUT(SWDOUT),
      .SWDOE(SWDOE), .SWDIN(SWDIN)
   );

   always #5 hclk = ~hclk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int hs_edge = 0;
   int rsp_cyc = -1;
   bit act = 1'b0;

   bit q_out[$];
   bit q_oe[$];
   bit q_in[$];
   bit cap[$];
   logic [2:0] ack_seq[$];
   logic [2:0]  e_ack;
   logic [31:0] e_rd;
   logic        e_perr;
   logic [3:0]  e_ret;

   always @(posedge hclk) cyc <= cyc + 1;

   task automatic chk(input string nm,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h cyc=%0d",
                  nm, got, exp, cyc);
      end
   endtask

   function automatic void push(bit o, bit e, bit i);
      q_out.push_back(o);
      q_oe.push_back(e);
      q_in.push_back(i);
   endfunction

   function automatic logic [63:0] capv(int lo, int n);
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++)
         if (lo + i < cap.size()) v[i] = cap[lo + i];
      return v;
   endfunction

   // one list entry per bit: host out, host oe, target response
   task automatic build(input bit lrst, input bit ap,
                        input bit rnw, input logic [1:0] a,
                        input logic [31:0] wd,
                        input logic [31:0] rd, input bit flip);
      logic [2:0] ak;
      int at;
      bit more;
      q_out.delete(); q_oe.delete(); q_in.delete();
      e_ack = '0; e_rd = '0; e_perr = 1'b0; e_ret = '0;
      if (lrst) begin
         for (int i = 0; i < 64; i++) push(i < 56, 1, 0);
         return;
      end
      at = 0;
      more = 1'b1;
      while (more) begin
         ak = ack_seq[(at < ack_seq.size()) ? at : ack_seq.size() - 1];
         push(1, 1, 0); push(ap, 1, 0); push(rnw, 1, 0);
         push(a[0], 1, 0); push(a[1], 1, 0);
         push(ap ^ rnw ^ a[0] ^ a[1], 1, 0);
         push(0, 1, 0); push(1, 1, 0);
         push(0, 0, 0);
         for (int i = 0; i < 3; i++) push(0, 0, ak[i]);
         if (ak == 3'b001 && rnw) begin
            for (int i = 0; i < 32; i++) push(0, 0, rd[i]);
            push(0, 0, (^rd) ^ flip);
         end
         push(0, 0, 0);
         if (ak == 3'b001 && !rnw) begin
            for (int i = 0; i < 32; i++) push(wd[i], 1, 0);
            push(^wd, 1, 0);
         end
         for (int i = 0; i < IC; i++) push(0, 1, 0);
         e_ack = ak;
         more = 1'b0;
`ifdef SWD_HOST_WAIT_RETRY_EN
         if (ak == 3'b010 && e_ret < RM) begin
            e_ret++;
            at++;
            more = 1'b1;
         end
`endif
      end
      if (e_ack == 3'b001 && rnw) begin
         e_rd = rd;
         e_perr = flip;
      end
   endtask

   always @(negedge hclk) begin
      int t, b, k;
      if (act) begin
         t = cyc - hs_edge;
         b = q_out.size();
         if (t >= 0 && t < b * P) begin
            k = t / P;
            chk("swdclk", SWDCLK, (t % P) >= CD);
            chk("swdout", SWDOUT, q_out[k]);
            chk("swdoe", SWDOE, q_oe[k]);
            chk("busy_valid", bus.rsp_valid, 0);
            chk("busy_ready", bus.req_ready, 0);
            if (t % P == CD) cap.push_back(SWDOUT);
         end else if (t == b * P) begin
            chk("rsp_valid", bus.rsp_valid, 1);
            chk("rsp_ack", bus.rsp_ack, e_ack);
            chk("rsp_rdata", bus.rsp_rdata, e_rd);
            chk("rsp_perr", bus.rsp_perr, e_perr);
            chk("rsp_retries", bus.rsp_retries, e_ret);
            chk("done_clk", SWDCLK, 0);
            chk("done_ready", bus.req_ready, 0);
            if (bus.rsp_valid && rsp_cyc < 0) rsp_cyc = cyc;
         end else if (t == b * P + 1) begin
            chk("post_valid", bus.rsp_valid, 0);
            chk("post_ready", bus.req_ready, 1);
            chk("post_oe", SWDOE, 1);
            chk("post_out", SWDOUT, 0);
            chk("post_clk", SWDCLK, 0);
         end
      end
   end

   task automatic run(input bit lrst, input bit ap,
                      input bit rnw, input logic [1:0] a,
                      input logic [31:0] wd,
                      input logic [31:0] rd, input bit flip,
                      input int abort_t);
      int n, t, k, b;
      build(lrst, ap, rnw, a, wd, rd, flip);
      b = q_out.size();
      n = 0;
      @(negedge hclk);
      while (!bus.req_ready && n < 100) begin
         @(negedge hclk);
         n++;
      end
      chk("ready_wait", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_lrst  = lrst;
      bus.req_apndp = ap;
      bus.req_rnw   = rnw;
      bus.req_addr  = a;
      bus.req_wdata = wd;
      hs_edge = cyc + 1;
      rsp_cyc = -1;
      cap.delete();
      act = 1'b1;
      for (int s = 0; s < b * P + 2; s++) begin
         @(negedge hclk);
         t = cyc - hs_edge;
         k = t / P;
         SWDIN = (k < b) ? q_in[k] : 1'b0;
         // junk on the request port while busy must be ignored
         if (t < b * P - 4) begin
            bus.req_valid = 1'($urandom);
            bus.req_lrst  = 1'($urandom);
            bus.req_apndp = 1'($urandom);
            bus.req_rnw   = 1'($urandom);
            bus.req_addr  = 2'($urandom);
            bus.req_wdata = $urandom;
         end else begin
            bus.req_valid = 1'b0;
         end
         if (abort_t >= 0 && t == abort_t) begin
            act = 1'b0;
            bus.req_valid = 1'b0;
            return;
         end
      end
      @(posedge hclk);
      act = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] pool[5];
      int nw;
      bus.req_valid = 1'b0;
      bus.req_lrst  = 1'b0;
      bus.req_apndp = 1'b0;
      bus.req_rnw   = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      RESETn = 1'b0;
      repeat (3) @(negedge hclk);
      chk("rst_clk", SWDCLK, 0);
      chk("rst_out", SWDOUT, 0);
      chk("rst_oe", SWDOE, 0);
      chk("rst_valid", bus.rsp_valid, 0);
      chk("rst_ack", bus.rsp_ack, 0);
      chk("rst_rdata", bus.rsp_rdata, 0);
      chk("rst_perr", bus.rsp_perr, 0);
      chk("rst_retries", bus.rsp_retries, 0);
      chk("rst_ready", bus.req_ready, 0);
      RESETn = 1'b1;
      @(negedge hclk);
      chk("rel_ready", bus.req_ready, 1);
      chk("rel_oe", SWDOE, 1);

      // DP read IDCODE
      ack_seq = '{3'b001};
      run(0, 0, 1, 2'd0, 32'h0, 32'h4BA00477, 0, -1);
      chk("idc_len", q_out.size(), 48);
      chk("idc_req", capv(0, 8), 64'hA5);
      chk("idc_ack", bus.rsp_ack, 3'b001);
      chk("idc_rdata", bus.rsp_rdata, 32'h4BA00477);
      chk("idc_perr", bus.rsp_perr, 0);
      chk("idc_lat", rsp_cyc - hs_edge + 1, 193);

      // AP write, A[3:2]=0
      ack_seq = '{3'b001};
      run(0, 1, 0, 2'd0, 32'h23000052, 32'h0, 0, -1);
      chk("wr_req", capv(0, 8), 64'hA3);
      chk("wr_data", capv(13, 32), 64'h23000052);
      chk("wr_par", capv(45, 1), 0);
      chk("wr_ack", bus.rsp_ack, 3'b001);
      chk("wr_rdata", bus.rsp_rdata, 0);

      // read with a flipped parity bit
      ack_seq = '{3'b001};
      run(0, 0, 1, 2'd3, 32'h0, 32'hDEADBEEF, 1, -1);
      chk("perr_flag", bus.rsp_perr, 1);
      chk("perr_rdata", bus.rsp_rdata, 32'hDEADBEEF);

      // FAULT
      ack_seq = '{3'b100};
      run(0, 1, 1, 2'd1, 32'h0, 32'h12345678, 0, -1);
      chk("flt_len", q_out.size(), 15);
      chk("flt_ack", bus.rsp_ack, 3'b100);
      chk("flt_rdata", bus.rsp_rdata, 0);
      chk("flt_lat", rsp_cyc - hs_edge + 1, 61);

      // WAIT x3 then OK
      ack_seq = '{3'b010, 3'b010, 3'b010, 3'b001};
      run(0, 1, 1, 2'd2, 32'h0, 32'hCAFEF00D, 0, -1);
`ifdef SWD_HOST_WAIT_RETRY_EN
      chk("wait_retries", bus.rsp_retries, 3);
      chk("wait_ack", bus.rsp_ack, 3'b001);
      chk("wait_rdata", bus.rsp_rdata, 32'hCAFEF00D);
      ack_seq = '{3'b010};
      run(0, 0, 1, 2'd1, 32'h0, 32'h1, 0, -1);
      chk("sat_retries", bus.rsp_retries, 15);
      chk("sat_ack", bus.rsp_ack, 3'b010);
`else
      chk("wait_retries", bus.rsp_retries, 0);
      chk("wait_ack", bus.rsp_ack, 3'b010);
      chk("wait_rdata", bus.rsp_rdata, 0);
`endif

      // line reset
      run(1, 0, 0, 2'd0, 32'h0, 32'h0, 0, -1);
      chk("lrst_bits", capv(0, 64), 64'h00FF_FFFF_FFFF_FFFF);
      chk("lrst_ack", bus.rsp_ack, 0);
      chk("lrst_lat", rsp_cyc - hs_edge + 1, 257);

      // randomized transactions
      for (int r = 0; r < 24; r++) begin
         pool[0] = 3'b001;
         pool[1] = 3'b001;
         pool[2] = 3'b100;
         pool[3] = 3'b111;
         pool[4] = 3'($urandom);
         ack_seq.delete();
         nw = $urandom_range(0, 2);
         for (int i = 0; i < nw; i++) ack_seq.push_back(3'b010);
         ack_seq.push_back(pool[$urandom_range(0, 4)]);
         run(($urandom_range(0, 7) == 0), 1'($urandom),
             1'($urandom), 2'($urandom), $urandom,
             $urandom, 1'($urandom), -1);
      end

      // reset mid-RDATA
      ack_seq = '{3'b001};
      run(0, 0, 1, 2'd0, 32'h0, 32'h55AA33CC, 0, 20 * P + 1);
      RESETn = 1'b0;
      @(negedge hclk);
      chk("abort_oe", SWDOE, 0);
      chk("abort_clk", SWDCLK, 0);
      chk("abort_valid", bus.rsp_valid, 0);
      chk("abort_ready", bus.req_ready, 0);
      repeat (3) begin
         @(negedge hclk);
         chk("abort_novalid", bus.rsp_valid, 0);
      end
      RESETn = 1'b1;
      @(negedge hclk);
      chk("abort_rel_ready", bus.req_ready, 1);
      chk("abort_rel_valid", bus.rsp_valid, 0);

      ack_seq = '{3'b001};
      run(0, 0, 1, 2'd1, 32'h0, 32'h0F0F1234, 0, -1);
      chk("after_rdata", bus.rsp_rdata, 32'h0F0F1234);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end
endmodule
